// File: rtl/three_dice_bist_ctrl.sv
// BIST sequencer for the three_dice evaluator: walks all 8 input vectors,
// samples y after a settle window, and grades the captured truth table.
module three_dice_bist_ctrl #(
    parameter logic [7:0]  EXPECTED      = 8'hE8,
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       y_in,
    output logic       d1,
    output logic       d2,
    output logic       d3,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] truth_table,
    output logic [7:0] mismatch_mask,
    output logic [7:0] run_count,
    output logic [7:0] fail_count
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_APPLY  = 2'd1;
    localparam logic [1:0] ST_SAMPLE = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    if (SETTLE_CYCLES == 0 || SETTLE_CYCLES > 15) begin : g_bad_settle
        $error("three_dice_bist_ctrl: SETTLE_CYCLES must be in 1..15");
    end

    logic [1:0] state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic [3:0] settle_q, settle_d;
    logic [2:0] dvec_q, dvec_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;
    logic [7:0] table_q, table_d;
    logic [7:0] mask_q, mask_d;
    logic [7:0] run_q, run_d;
    logic [7:0] fail_q, fail_d;
    logic [7:0] table_next;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        settle_d   = settle_q;
        pass_d     = pass_q;
        table_d    = table_q;
        mask_d     = mask_q;
        run_d      = run_q;
        fail_d     = fail_q;
        table_next = table_q;
        table_next[idx_q] = y_in;

        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_d  = ST_APPLY;
                    idx_d    = '0;
                    settle_d = '0;
                    table_d  = '0;
                    mask_d   = '0;
                    pass_d   = 1'b0;
                end
            end
            ST_APPLY: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    pass_d  = 1'b0;
                end else begin
                    settle_d = settle_q + 4'd1;
                    if (settle_q == SETTLE_LAST) begin
                        state_d = ST_SAMPLE;
                    end
                end
            end
            ST_SAMPLE: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    pass_d  = 1'b0;
                end else begin
                    table_d = table_next;
                    if (idx_q == 3'd7) begin
                        // Grade on the table including the bit captured this edge.
                        state_d = ST_DONE;
                        pass_d  = (table_next == EXPECTED);
                        mask_d  = table_next ^ EXPECTED;
                        run_d   = run_q + {7'd0, (run_q != 8'hFF)};
                        if (table_next != EXPECTED) begin
                            fail_d = fail_q + {7'd0, (fail_q != 8'hFF)};
                        end
                    end else begin
                        state_d  = ST_APPLY;
                        idx_d    = idx_q + 3'd1;
                        settle_d = '0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Registered outputs are derived from the next state so they line up with it.
        busy_d = (state_d == ST_APPLY) || (state_d == ST_SAMPLE);
        done_d = (state_d == ST_DONE);
        dvec_d = busy_d ? idx_d : 3'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            settle_q <= '0;
            dvec_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            table_q  <= '0;
            mask_q   <= '0;
            run_q    <= '0;
            fail_q   <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            settle_q <= settle_d;
            dvec_q   <= dvec_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
            table_q  <= table_d;
            mask_q   <= mask_d;
            run_q    <= run_d;
            fail_q   <= fail_d;
        end
    end

    assign d1            = dvec_q[2];
    assign d2            = dvec_q[1];
    assign d3            = dvec_q[0];
    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign truth_table   = table_q;
    assign mismatch_mask = mask_q;
    assign run_count     = run_q;
    assign fail_count    = fail_q;

endmodule

// File: tb/tb_three_dice_bist_ctrl.sv
// Bench for three_dice_bist_ctrl: drives behavioural three_dice models and
// compares the sequencer's results against truth tables built from the rules.
module tb_three_dice_bist_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1, start = 1'b0, abort = 1'b0, start1 = 1'b0, abort1 = 1'b0;
    logic y_in, y1;
    logic d1, d2, d3, busy, done, pass;
    logic [7:0] tt, mm, rc, fc;
    logic e_d1, e_d2, e_d3, e_busy, e_done, e_pass;
    logic [7:0] e_tt, e_mm, e_rc, e_fc;
    logic [2:0] dv, dv1;
    logic r1 = 1'b0, r2 = 1'b0, s1 = 1'b0, s2 = 1'b0;
    int mode = 0;
    logic [7:0] rnd_tbl = '0;

    int vectors = 0;
    int miscompares = 0;
    int exp_run = 0;
    int exp_fail = 0;

    three_dice_bist_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .y_in(y_in),
        .d1(d1), .d2(d2), .d3(d3), .busy(busy), .done(done), .pass(pass),
        .truth_table(tt), .mismatch_mask(mm), .run_count(rc), .fail_count(fc)
    );

    three_dice_bist_ctrl #(.EXPECTED(8'hE8), .SETTLE_CYCLES(1)) dut_s1 (
        .clk(clk), .rst(rst), .start(start1), .abort(abort1), .y_in(y1),
        .d1(e_d1), .d2(e_d2), .d3(e_d3), .busy(e_busy), .done(e_done), .pass(e_pass),
        .truth_table(e_tt), .mismatch_mask(e_mm), .run_count(e_rc), .fail_count(e_fc)
    );

    assign dv  = {d1, d2, d3};
    assign dv1 = {e_d1, e_d2, e_d3};

    function automatic logic maj3(input logic [2:0] v);
        return (v[2] & v[1]) | (v[1] & v[0]) | (v[2] & v[0]);
    endfunction

    function automatic logic [7:0] maj_table();
        logic [7:0] t;
        for (int i = 0; i < 8; i++) t[i] = maj3(3'(i));
        return t;
    endfunction

    // Table seen through a 2-register majority model: sample i lands on edge
    // (S+1)(i+1) and sees the vector that was on d two cycles before.
    function automatic logic [7:0] delayed_table(input int s);
        logic [7:0] t;
        for (int i = 0; i < 8; i++) begin
            int c = (s + 1) * (i + 1) - 2;
            int v = (c < 1) ? 0 : (c - 1) / (s + 1);
            t[i] = maj3(3'(v));
        end
        return t;
    endfunction

    // three_dice behavioural models
    always_comb begin
        case (mode)
            0: y_in = maj3(dv);
            1: y_in = ~maj3(dv);
            2: y_in = 1'b0;
            3: y_in = r2;
            default: y_in = rnd_tbl[dv];
        endcase
    end
    assign y1 = s2;

    always @(posedge clk) begin
        r1 <= maj3(dv);
        r2 <= r1;
        s1 <= maj3(dv1);
        s2 <= s1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic note_run(input logic p);
        if (exp_run < 255) exp_run++;
        if (!p && exp_fail < 255) exp_fail++;
    endtask

    // Starts a run and waits (bounded) for done; cyc = cycle of done or 0.
    task automatic do_run(output int cyc);
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 0;
        for (int c = 1; c <= 200; c++) begin
            if (done) begin
                cyc = c;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        exp_run = 0; exp_fail = 0;
        vectors++;
        if ({dv, busy, done, pass} !== 6'b0) begin
            miscompares++; $display("FAIL reset_ctl: got %b expected 000000", {dv, busy, done, pass});
        end
        vectors++;
        if ({tt, mm, rc, fc} !== 32'h0) begin
            miscompares++; $display("FAIL reset_regs: got %h expected 00000000", {tt, mm, rc, fc});
        end
        vectors++;
        if ({dv1, e_busy, e_done, e_pass, e_tt, e_mm, e_rc, e_fc} !== 38'h0) begin
            miscompares++; $display("FAIL reset_s1: got %h expected 0", {dv1, e_busy, e_done, e_pass, e_tt, e_mm, e_rc, e_fc});
        end
    endtask

    task automatic test_majority();
        logic [4:0] got, expv;
        mode = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 25; c++) begin
            expv = {(c <= 24), (c == 25), 3'((c <= 24) ? (c - 1) / 3 : 0)};
            got = {busy, done, dv};
            vectors++;
            if (got !== expv) begin
                miscompares++; $display("FAIL maj_cycle%0d: got %b expected %b", c, got, expv);
            end
            if (c == 25) begin
                note_run(1'b1);
                vectors++;
                if ({tt, pass, mm} !== {maj_table(), 1'b1, 8'h00}) begin
                    miscompares++; $display("FAIL maj_result: got tt=%h pass=%b mm=%h expected tt=%h pass=1 mm=00", tt, pass, mm, maj_table());
                end
                vectors++;
                if ({rc, fc} !== {8'(exp_run), 8'(exp_fail)}) begin
                    miscompares++; $display("FAIL maj_counts: got %0d/%0d expected %0d/%0d", rc, fc, exp_run, exp_fail);
                end
            end
            tick();
        end
        repeat (5) tick();
        vectors++;
        if ({done, busy, pass, tt} !== {2'b00, 1'b1, maj_table()}) begin
            miscompares++; $display("FAIL maj_hold: got %b %b %b %h expected 0 0 1 %h", done, busy, pass, tt, maj_table());
        end
    endtask

    task automatic test_faulty_models();
        int cyc;
        mode = 1;
        do_run(cyc);
        note_run(1'b0);
        vectors++;
        if ({cyc, tt, pass, mm} !== {32'd25, ~maj_table(), 1'b0, 8'hFF}) begin
            miscompares++; $display("FAIL inverted: got cyc=%0d tt=%h pass=%b mm=%h expected cyc=25 tt=%h pass=0 mm=ff", cyc, tt, pass, mm, ~maj_table());
        end
        vectors++;
        if ({rc, fc} !== {8'(exp_run), 8'(exp_fail)}) begin
            miscompares++; $display("FAIL inverted_counts: got %0d/%0d expected %0d/%0d", rc, fc, exp_run, exp_fail);
        end
        tick();
        mode = 2;
        do_run(cyc);
        note_run(1'b0);
        vectors++;
        if ({cyc, tt, pass, mm} !== {32'd25, 8'h00, 1'b0, maj_table()}) begin
            miscompares++; $display("FAIL stuck0: got cyc=%0d tt=%h pass=%b mm=%h expected cyc=25 tt=00 pass=0 mm=%h", cyc, tt, pass, mm, maj_table());
        end
        tick();
    endtask

    task automatic test_registered_model();
        int cyc;
        logic [4:0] got, expv;
        logic [7:0] t1;
        mode = 3;
        repeat (4) tick();
        do_run(cyc);
        note_run(delayed_table(2) == 8'hE8);
        vectors++;
        if ({cyc, tt, pass} !== {32'd25, delayed_table(2), 1'b1}) begin
            miscompares++; $display("FAIL reg_settle2: got cyc=%0d tt=%h pass=%b expected cyc=25 tt=%h pass=1", cyc, tt, pass, delayed_table(2));
        end
        tick();
        t1 = delayed_table(1);
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int c = 1; c <= 17; c++) begin
            expv = {(c <= 16), (c == 17), 3'((c <= 16) ? (c - 1) / 2 : 0)};
            got = {e_busy, e_done, dv1};
            vectors++;
            if (got !== expv) begin
                miscompares++; $display("FAIL s1_cycle%0d: got %b expected %b", c, got, expv);
            end
            if (c == 17) begin
                vectors++;
                if ({e_tt, e_pass, e_mm, e_rc, e_fc} !== {t1, (t1 == 8'hE8), t1 ^ 8'hE8, 8'd1, 8'((t1 == 8'hE8) ? 0 : 1)}) begin
                    miscompares++; $display("FAIL reg_settle1: got tt=%h pass=%b mm=%h rc=%0d fc=%0d expected tt=%h pass=0", e_tt, e_pass, e_mm, e_rc, e_fc, t1);
                end
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        int ndone = 0, dcyc = 0;
        mode = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 32; c++) begin
            if (done) begin
                ndone++; dcyc = c;
            end
            start = (c == 5 || c == 24 || c == 25);
            tick();
        end
        start = 1'b0;
        note_run(1'b1);
        vectors++;
        if ({ndone, dcyc, rc} !== {32'd1, 32'd25, 8'(exp_run)}) begin
            miscompares++; $display("FAIL restart_ignored: got ndone=%0d at %0d rc=%0d expected 1 at 25 rc=%0d", ndone, dcyc, rc, exp_run);
        end
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        ndone = 0;
        for (int c = 0; c < 30; c++) begin
            if (busy || done) ndone++;
            tick();
        end
        vectors++;
        if ({ndone, rc, pass, tt} !== {32'd0, 8'(exp_run), 1'b1, maj_table()}) begin
            miscompares++; $display("FAIL start_abort_idle: got active=%0d rc=%0d pass=%b tt=%h expected 0 %0d 1 %h", ndone, rc, pass, tt, exp_run, maj_table());
        end
    endtask

    task automatic abort_at(input int a, input logic [7:0] tbl, input string nm);
        int ndone = 0;
        logic [7:0] expt = '0;
        mode = 4;
        rnd_tbl = tbl;
        for (int i = 0; i < 8; i++) if (3 * i + 3 < a) expt[i] = tbl[i];
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c < a; c++) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        vectors++;
        if ({busy, dv, done} !== 5'b0) begin
            miscompares++; $display("FAIL %s_idle: got %b expected 00000", nm, {busy, dv, done});
        end
        for (int c = 0; c < 30; c++) begin
            if (done || busy) ndone++;
            tick();
        end
        vectors++;
        if ({ndone, pass, tt, rc, fc} !== {32'd0, 1'b0, expt, 8'(exp_run), 8'(exp_fail)}) begin
            miscompares++; $display("FAIL %s_result: got act=%0d pass=%b tt=%h rc=%0d fc=%0d expected 0 0 %h %0d %0d", nm, ndone, pass, tt, rc, fc, expt, exp_run, exp_fail);
        end
    endtask

    task automatic test_abort();
        int cyc, a;
        abort_at(10, 8'hFF, "abort10");
        for (int k = 0; k < 4; k++) begin
            a = $urandom_range(1, 24);
            if (a % 3 == 0) a = a - 1;
            abort_at(a, 8'($urandom), "abort_rand");
        end
        mode = 0;
        do_run(cyc);
        note_run(1'b1);
        vectors++;
        if ({cyc, tt, pass, rc, fc} !== {32'd25, maj_table(), 1'b1, 8'(exp_run), 8'(exp_fail)}) begin
            miscompares++; $display("FAIL after_abort: got cyc=%0d tt=%h pass=%b rc=%0d fc=%0d", cyc, tt, pass, rc, fc);
        end
        tick();
    endtask

    task automatic test_random_tables();
        int cyc;
        logic [7:0] t;
        mode = 4;
        for (int k = 0; k < 8; k++) begin
            t = (k == 0) ? 8'hE8 : 8'($urandom);
            rnd_tbl = t;
            do_run(cyc);
            note_run(t == 8'hE8);
            vectors++;
            if ({cyc, tt, pass, mm, rc, fc} !== {32'd25, t, (t == 8'hE8), t ^ 8'hE8, 8'(exp_run), 8'(exp_fail)}) begin
                miscompares++; $display("FAIL rand_tbl%0d: got cyc=%0d tt=%h pass=%b mm=%h rc=%0d fc=%0d expected tt=%h", k, cyc, tt, pass, mm, rc, fc, t);
            end
            tick();
        end
    endtask

    task automatic test_reset_midrun();
        mode = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c < 12; c++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_run = 0; exp_fail = 0;
        vectors++;
        if ({dv, busy, done, pass, tt, mm, rc, fc} !== 38'h0) begin
            miscompares++; $display("FAIL reset_midrun: got %h expected 0", {dv, busy, done, pass, tt, mm, rc, fc});
        end
        repeat (30) tick();
        vectors++;
        if ({busy, done, rc} !== 10'h0) begin
            miscompares++; $display("FAIL reset_discard: got busy=%b done=%b rc=%0d expected 0", busy, done, rc);
        end
    endtask

    task automatic test_saturation();
        int cyc, late = 0;
        mode = 2;
        for (int k = 0; k < 256; k++) begin
            do_run(cyc);
            if (cyc != 25) late++;
            note_run(1'b0);
            tick();
        end
        vectors++;
        if (late !== 0) begin
            miscompares++; $display("FAIL sat_timing: got %0d late runs expected 0", late);
        end
        vectors++;
        if ({rc, fc} !== {8'(exp_run), 8'(exp_fail)} || exp_run != 255) begin
            miscompares++; $display("FAIL saturation: got %0d/%0d expected %0d/%0d", rc, fc, exp_run, exp_fail);
        end
    endtask

    initial begin
        test_reset();
        test_majority();
        test_faulty_models();
        test_registered_model();
        test_back_to_back();
        test_abort();
        test_random_tables();
        test_reset_midrun();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
